// File: rtl/status_display_seq_pkg.sv
// status_display_pkg: display codes and FSM state type shared by the status
// display block, its blink timer and its interface users.
package status_display_pkg;

  // state-message codes, one per vending FSM state 0..4
  localparam logic [7:0] DISP_ST0       = 8'h00;
  localparam logic [7:0] DISP_ST1       = 8'h01;
  localparam logic [7:0] DISP_ST2       = 8'h02;
  localparam logic [7:0] DISP_ST3       = 8'h03;
  localparam logic [7:0] DISP_ST4       = 8'h04;  // RETURN_MONEY
  // event-message codes
  localparam logic [7:0] DISP_PROD_DONE = 8'h10;
  localparam logic [7:0] DISP_CHG_DONE  = 8'h11;
  localparam logic [7:0] DISP_CANCEL    = 8'h12;
  localparam logic [7:0] DISP_ERR       = 8'hE0;  // OR'd with the 4-bit error code
  localparam logic [7:0] DISP_UNKNOWN   = 8'hFF;

  typedef enum logic {SHOW_STATE, HOLD_EVT} disp_state_t;

endpackage

// File: rtl/status_display_seq_if.sv
// status_display_seq_if: groups the enable, state/event inputs and the display
// outputs of status_display_seq.
//   master: drives display_status_en, state_out, events; reads display outputs
//   slave : the display block itself
// Optional STATUS_ERR_EN adds err_valid / err_code.
interface status_display_seq_if #(
  parameter int STATE_W = 3,
  parameter int LED_N   = 4
);
  logic               display_status_en;
  logic [STATE_W-1:0] state_out;
  logic               product_dispense_done;
  logic               change_dispense_done;
  logic               cancel;
  logic [7:0]         status_display;
  logic [LED_N-1:0]   led_indicators;
  logic               msg_busy;
`ifdef STATUS_ERR_EN
  logic               err_valid;
  logic [3:0]         err_code;

  modport master (output display_status_en, state_out, product_dispense_done,
                         change_dispense_done, cancel, err_valid, err_code,
                  input  status_display, led_indicators, msg_busy);
  modport slave  (input  display_status_en, state_out, product_dispense_done,
                         change_dispense_done, cancel, err_valid, err_code,
                  output status_display, led_indicators, msg_busy);
`else
  modport master (output display_status_en, state_out, product_dispense_done,
                         change_dispense_done, cancel,
                  input  status_display, led_indicators, msg_busy);
  modport slave  (input  display_status_en, state_out, product_dispense_done,
                         change_dispense_done, cancel,
                  output status_display, led_indicators, msg_busy);
`endif
endinterface

// File: rtl/status_display_seq_blink_timer.sv
// status_blink_timer: free-running blink phase, BLINK_HALF cycles per half.
//   clk, rst_n : clock, async active-low reset
//   restart    : forces the phase "on" and restarts the half-period this cycle
//   phase      : current blink phase (combinational from regs and restart)
module status_blink_timer #(
  parameter int BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase
);
  import status_display_pkg::*;

  localparam int CW = (BLINK_HALF < 2) ? 1 : $clog2(BLINK_HALF);

  logic [CW-1:0] cnt, cur_cnt;
  logic          ph, cur_ph;

  // restart takes effect in the same cycle so the first sampled phase is "on"
  assign cur_cnt = restart ? '0 : cnt;
  assign cur_ph  = restart ? 1'b1 : ph;
  assign phase   = cur_ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else if (cur_cnt == CW'(BLINK_HALF - 1)) begin
      cnt <= '0;
      ph  <= ~cur_ph;
    end else begin
      cnt <= cur_cnt + CW'(1);
      ph  <= cur_ph;
    end
  end
endmodule

// File: rtl/status_display_seq.sv
// status_display_seq: turns the vending FSM state and done/cancel events into a
// registered 8-bit display code, per-state LEDs and a msg_busy flag.
//   clk, rst_n : clock, async active-low reset
//   bus (slave): display_status_en, state_out, product/change done, cancel in;
//                status_display, led_indicators, msg_busy out
// Event messages are held HOLD_CYCLES cycles; state 4 blinks its LED(s).
// Optional macro STATUS_ERR_EN: err_valid/err_code, top-priority 0xE0|code
// message with all LEDs blinking while held.
module status_display_seq #(
  parameter int STATE_W     = 3,
  parameter int LED_N       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int BLINK_HALF  = 4
) (
  input logic              clk,
  input logic              rst_n,
  status_display_seq_if.slave bus
);
  import status_display_pkg::*;

  disp_state_t        st;
  logic [7:0]         hold_cnt;
  logic [7:0]         disp_q;
  logic [LED_N-1:0]   led_q;
  logic               busy_q;
  logic [STATE_W-1:0] prev_state;
  logic               prev_vld;
  logic               phase;
  logic               restart;
  logic               evt_any;
  logic [7:0]         evt_code;
  logic [7:0]         show_code;
  logic [LED_N-1:0]   led_dec;
  logic [LED_N-1:0]   led_base;
  logic               st4;

  assign st4 = (bus.state_out == STATE_W'(4));

  // blink phase restarts on any state change, and on the first cycle out of reset
  assign restart = !prev_vld || (bus.state_out != prev_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state <= '0;
      prev_vld   <= 1'b0;
    end else begin
      prev_state <= bus.state_out;
      prev_vld   <= 1'b1;
    end
  end

  status_blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk(clk), .rst_n(rst_n), .restart(restart), .phase(phase)
  );

  for (genvar i = 0; i < LED_N; i++) begin : g_led
    assign led_dec[i] = (bus.state_out == STATE_W'(i));
  end

  // state 4: its own LED blinks when present, else the whole bar blinks
  if (LED_N > 4) begin : g_blink_one
    assign led_base = (st4 && !phase) ? '0 : led_dec;
  end else begin : g_blink_all
    assign led_base = st4 ? {LED_N{phase}} : led_dec;
  end

  always_comb begin
    show_code = DISP_UNKNOWN;
    case (32'(bus.state_out))
      32'd0: show_code = DISP_ST0;
      32'd1: show_code = DISP_ST1;
      32'd2: show_code = DISP_ST2;
      32'd3: show_code = DISP_ST3;
      32'd4: show_code = DISP_ST4;
      default: show_code = DISP_UNKNOWN;
    endcase
  end

  always_comb begin
    evt_any  = bus.cancel | bus.change_dispense_done | bus.product_dispense_done;
    evt_code = DISP_PROD_DONE;
    if (bus.cancel)                    evt_code = DISP_CANCEL;
    else if (bus.change_dispense_done) evt_code = DISP_CHG_DONE;
`ifdef STATUS_ERR_EN
    if (bus.err_valid) begin
      evt_any  = 1'b1;
      evt_code = DISP_ERR | {4'h0, bus.err_code};
    end
`endif
  end

`ifdef STATUS_ERR_EN
  logic err_hold;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= SHOW_STATE;
      hold_cnt <= '0;
      disp_q   <= DISP_ST0;
      led_q    <= '0;
      busy_q   <= 1'b0;
`ifdef STATUS_ERR_EN
      err_hold <= 1'b0;
`endif
    end else if (!bus.display_status_en) begin
      st       <= SHOW_STATE;
      hold_cnt <= '0;
      disp_q   <= DISP_ST0;
      led_q    <= '0;
      busy_q   <= 1'b0;
`ifdef STATUS_ERR_EN
      err_hold <= 1'b0;
`endif
    end else begin
      led_q <= led_base;
      if (evt_any) begin
        // new event wins over expiry, so a held-high event keeps reloading
        st       <= HOLD_EVT;
        hold_cnt <= 8'(HOLD_CYCLES);
        disp_q   <= evt_code;
        busy_q   <= 1'b1;
`ifdef STATUS_ERR_EN
        err_hold <= bus.err_valid;
        if (bus.err_valid) led_q <= {LED_N{phase}};
`endif
      end else if (st == HOLD_EVT && hold_cnt != 8'd1) begin
        hold_cnt <= hold_cnt - 8'd1;
`ifdef STATUS_ERR_EN
        if (err_hold) led_q <= {LED_N{phase}};
`endif
      end else begin
        // idle, or the counter reaches 0 on this edge
        st       <= SHOW_STATE;
        hold_cnt <= '0;
        disp_q   <= show_code;
        busy_q   <= 1'b0;
`ifdef STATUS_ERR_EN
        err_hold <= 1'b0;
`endif
      end
    end
  end

  assign bus.status_display = disp_q;
  assign bus.led_indicators = led_q;
  assign bus.msg_busy       = busy_q;

endmodule

// File: tb/tb_status_display_seq.sv
// Scoreboard bench for status_display_seq (HOLD_CYCLES=4, BLINK_HALF=2, LED_N=4).
// Each stimulus step drives inputs on the falling edge and queues the outputs
// expected after the next rising edge; a monitor pops and compares.
module tb_status_display_seq;
  import status_display_pkg::*;

  localparam int STATE_W = 3;
  localparam int LED_N   = 4;

  typedef struct {
    string      name;
    logic [7:0] disp;
    logic [3:0] led;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  status_display_seq_if #(.STATE_W(STATE_W), .LED_N(LED_N)) bus ();

  status_display_seq #(.STATE_W(STATE_W), .LED_N(LED_N), .HOLD_CYCLES(4),
                       .BLINK_HALF(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic compare(input string name, input logic [7:0] d,
                         input logic [3:0] l, input logic b);
    checks++;
    if (bus.status_display !== d || bus.led_indicators !== l || bus.msg_busy !== b) begin
      errors++;
      $display("FAIL %s: got disp=%h led=%b busy=%b, want disp=%h led=%b busy=%b",
               name, bus.status_display, bus.led_indicators, bus.msg_busy, d, l, b);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e.name, e.disp, e.led, e.busy);
      end
    end
  end

  task automatic step(input string name, input logic en, input logic [2:0] s,
                      input logic p, input logic c, input logic x,
                      input logic [7:0] d, input logic [3:0] l, input logic b);
    exp_t e;
    @(negedge clk);
    bus.display_status_en     = en;
    bus.state_out             = s;
    bus.product_dispense_done = p;
    bus.change_dispense_done  = c;
    bus.cancel                = x;
    e.name = name; e.disp = d; e.led = l; e.busy = b;
    sb.push_back(e);
  endtask

  initial begin
    bus.display_status_en     = 1'b0;
    bus.state_out             = '0;
    bus.product_dispense_done = 1'b0;
    bus.change_dispense_done  = 1'b0;
    bus.cancel                = 1'b0;
`ifdef STATUS_ERR_EN
    bus.err_valid = 1'b0;
    bus.err_code  = 4'h0;
`endif
    repeat (2) @(negedge clk);
    compare("reset_state", 8'h00, 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Test 1: state stepping
    step("t1_s0", 1, 0, 0, 0, 0, 8'h00, 4'b0001, 0);
    step("t1_s1", 1, 1, 0, 0, 0, 8'h01, 4'b0010, 0);
    step("t1_s2", 1, 2, 0, 0, 0, 8'h02, 4'b0100, 0);

    // Test 2: product done pulse, 4-cycle hold
    step("t2_load", 1, 2, 1, 0, 0, 8'h10, 4'b0100, 1);
    for (int i = 0; i < 3; i++) step("t2_hold", 1, 2, 0, 0, 0, 8'h10, 4'b0100, 1);
    step("t2_expire", 1, 2, 0, 0, 0, 8'h02, 4'b0100, 0);

    // Test 3: priority, replacement and reload, expiry-cycle replacement
    step("t3_prio", 1, 2, 0, 1, 1, 8'h12, 4'b0100, 1);
    step("t3_hold", 1, 2, 0, 0, 0, 8'h12, 4'b0100, 1);
    step("t3_chg", 1, 2, 0, 1, 0, 8'h11, 4'b0100, 1);
    for (int i = 0; i < 3; i++) step("t3_chg_hold", 1, 2, 0, 0, 0, 8'h11, 4'b0100, 1);
    step("t3_expiry_evt", 1, 2, 1, 0, 0, 8'h10, 4'b0100, 1);
    for (int i = 0; i < 3; i++) step("t3_prod_hold", 1, 2, 0, 0, 0, 8'h10, 4'b0100, 1);
    step("t3_expire", 1, 2, 0, 0, 0, 8'h02, 4'b0100, 0);

    // held-high event keeps reloading
    for (int i = 0; i < 3; i++) step("lvl_high", 1, 2, 1, 0, 0, 8'h10, 4'b0100, 1);
    for (int i = 0; i < 3; i++) step("lvl_hold", 1, 2, 0, 0, 0, 8'h10, 4'b0100, 1);
    step("lvl_expire", 1, 2, 0, 0, 0, 8'h02, 4'b0100, 0);

    // Test 4: RETURN_MONEY blink, 2 on / 2 off starting on
    for (int i = 0; i < 10; i++)
      step("t4_blink", 1, 4, 0, 0, 0, 8'h04, ((i % 4) < 2) ? 4'b1111 : 4'b0000, 0);

    // Test 5: enable dropped mid-hold, events ignored while disabled
    step("t5_s1", 1, 1, 0, 0, 0, 8'h01, 4'b0010, 0);
    step("t5_load", 1, 1, 1, 0, 0, 8'h10, 4'b0010, 1);
    step("t5_hold", 1, 1, 0, 0, 0, 8'h10, 4'b0010, 1);
    step("t5_en_off", 0, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    step("t5_evt_ignored", 0, 1, 0, 0, 1, 8'h00, 4'b0000, 0);
    step("t5_en_on", 1, 1, 0, 0, 0, 8'h01, 4'b0010, 0);
    step("t5_no_residual", 1, 1, 0, 0, 0, 8'h01, 4'b0010, 0);

    // Test 6: async reset mid-hold, then unknown state
    step("t6_load", 1, 1, 0, 0, 1, 8'h12, 4'b0010, 1);
    step("t6_hold", 1, 1, 0, 0, 0, 8'h12, 4'b0010, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare("t6_async_reset", 8'h00, 4'b0000, 1'b0);
    step("t6_in_reset", 1, 5, 0, 0, 0, 8'h00, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_unknown", 1, 5, 0, 0, 0, 8'hFF, 4'b0000, 0);
    step("t6_unknown2", 1, 5, 0, 0, 0, 8'hFF, 4'b0000, 0);

    // drain the scoreboard with a bound
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/status_display_seq.md
STATUS_DISPLAY_SEQ -- requirements
Module: status_display_seq

Interface
REQ-001 SHALL have parameter STATE_W, default 3: width of state_out.
REQ-002 SHALL have parameter LED_N, default 4: LED count, one LED per state code 0..LED_N-1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 8, legal range 1..255: event-message hold time in clk cycles.
REQ-004 SHALL have parameter BLINK_HALF, default 4, legal range >=1: blink half-period in clk cycles.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port display_status_en, input, 1: global enable.
REQ-008 SHALL have port state_out, input, STATE_W: vending FSM state code.
REQ-009 SHALL have port product_dispense_done, input, 1: product-done event.
REQ-010 SHALL have port change_dispense_done, input, 1: change-done event.
REQ-011 SHALL have port cancel, input, 1: cancel event.
REQ-012 SHALL have port status_display, output, 8: display code.
REQ-013 SHALL have port led_indicators, output, LED_N: LED drive.
REQ-014 SHALL have port msg_busy, output, 1: high while an event message is held.

Function
REQ-015 SHALL register all outputs; every response appears exactly one clk after the sampling edge.
REQ-016 SHALL implement FSM states SHOW_STATE and HOLD_EVT.
REQ-017 In SHOW_STATE, status_display SHALL be 0x00/0x01/0x02/0x03/0x04 for state_out 0..4, and 0xFF for any other code.
REQ-018 An event sampled high SHALL move the FSM to HOLD_EVT, load the hold counter with HOLD_CYCLES, and show CANCELLED 0x12 > CHANGE_DONE 0x11 > PRODUCT_DONE 0x10, by this priority when events coincide.
REQ-019 In HOLD_EVT, the counter SHALL decrement each cycle; on the cycle it reaches 0, the FSM SHALL return to SHOW_STATE.
REQ-020 An event arriving during HOLD_EVT SHALL replace the message and reload the counter, including on the expiry cycle.
REQ-021 Events SHALL be level-sampled; a held-high event reloads the counter every cycle.
REQ-022 msg_busy SHALL be 1 exactly while the FSM is in HOLD_EVT.
REQ-023 led_indicators[i] SHALL be 1 when state_out==i, for i<LED_N; out-of-range codes SHALL give all zeros.
REQ-024 While state_out==4 (RETURN_MONEY), LED 4 (if LED_N>4) and otherwise all LEDs SHALL blink, toggling every BLINK_HALF cycles, starting on.
REQ-025 The blink phase counter SHALL restart whenever state_out changes.
REQ-026 display_status_en=0 SHALL, next cycle, force status_display=0x00, led_indicators=0 and msg_busy=0, and SHALL reset the FSM to SHOW_STATE.
REQ-027 Events SHALL be ignored while display_status_en=0.

Reset
REQ-028 rst_n low SHALL asynchronously set status_display=0x00, led_indicators=0, msg_busy=0, FSM=SHOW_STATE, and hold and blink counters=0.
REQ-029 Reset asserted mid-hold SHALL discard the held message; after release, the first output SHALL reflect the state input only.

Configuration
REQ-030 With STATUS_ERR_EN defined, the block SHALL add inputs err_valid (1) and err_code (4).
REQ-031 With STATUS_ERR_EN defined, err_valid SHALL have top priority and show 0xE0|err_code, held like any other event.
REQ-032 With STATUS_ERR_EN defined, while an error message is held, all LEDs SHALL blink.
REQ-033 Without STATUS_ERR_EN, those ports and that logic SHALL be absent, and behaviour SHALL be identical to REQ-015..REQ-027.

Structure
REQ-034 Package status_display_pkg SHALL hold all display-code constants (0x00-0x04, 0x10-0x12, 0xE0, 0xFF) and the FSM state typedef.
REQ-035 Sub-module status_blink_timer (parameter BLINK_HALF; inputs clk, rst_n, restart; output phase) SHALL generate the blink phase.

Verification (HOLD_CYCLES=4, BLINK_HALF=2, LED_N=4)
REQ-036 Test 1: en=1, state_out stepping 0, 1, 2 -> status_display 0x00, 0x01, 0x02 and led 0001, 0010, 0100, each one cycle later.
REQ-037 Test 2: state 2, product_done pulsed 1 cycle -> 0x10 with msg_busy=1 for 4 cycles, then 0x02 and msg_busy=0.
REQ-038 Test 3: cancel and change_done high in the same cycle -> 0x12; change_done pulsed during that hold -> 0x11 with the counter reloaded to 4.
REQ-039 Test 4: state 4 held for 10 cycles -> status_display 0x04, led toggling 1111/0000 every 2 cycles, starting at 1111.
REQ-040 Test 5: en dropped mid-hold -> next cycle 0x00, led 0, msg_busy 0; en raised again -> state message, no residual event.
REQ-041 Test 6: rst_n low mid-hold -> outputs 0 immediately (asynchronous); state_out=5 after release -> 0xFF, led 0000.
